// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - opcode constants, opcode field bounds and fetch FSM states
package instr_fetch_unit_pkg;

    localparam int OPC_FIELD_MSB = 31;
    localparam int OPC_FIELD_LSB = 27;

    localparam logic [4:0] OPD_NOP = 5'b00000;
    localparam logic [4:0] OPD_NOT = 5'b10000;
    localparam logic [4:0] OPD_AND = 5'b10001;
    localparam logic [4:0] OPD_OR  = 5'b10010;
    localparam logic [4:0] OPD_NEG = 5'b10100;
    localparam logic [4:0] OPD_ADD = 5'b10101;
    localparam logic [4:0] OPD_SUB = 5'b10110;
    localparam logic [4:0] OPD_HLT = 5'b11111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    function automatic logic is_halt(input logic [4:0] opcode);
        return opcode == OPD_HLT;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, one-entry instruction register and RUN/DRAIN/HALTED fetch FSM
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16,
    parameter int OPC_MSB   = OPC_FIELD_MSB,
    parameter int OPC_LSB   = OPC_FIELD_LSB
) (
    input  logic                 clk,
    input  logic                 reset_L,
    output logic [BITS_ADDR-1:0] mem_address,
    input  logic [BITS_DATA-1:0] mem_data,
    output logic [BITS_DATA-1:0] instr_out,
    output logic [BITS_ADDR-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 redirect_valid,
    input  logic [BITS_ADDR-1:0] redirect_addr,
    output logic                 halted,
    output logic [31:0]          fetch_count
);

    fetch_state_t         state, state_next;
    logic [BITS_ADDR-1:0] pc;
    logic                 transfer;
    logic                 load;
    logic                 load_is_hlt;

    assign mem_address = pc;
    assign transfer    = instr_valid && instr_ready;
    // Redirect wins over everything, so it also suppresses the load of the stale word.
    assign load        = (state == ST_RUN) && (!instr_valid || instr_ready) && !redirect_valid;
    assign load_is_hlt = is_halt(mem_data[OPC_MSB:OPC_LSB]);

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (load && load_is_hlt) state_next = ST_DRAIN;
                ST_DRAIN: if (transfer) state_next = ST_HALTED;
                default:  state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pc          <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_addr;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (load) begin
            instr_out   <= mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + BITS_ADDR'(1);
        end else if (state == ST_DRAIN && transfer) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fetch_count <= '0;
        end else if (transfer) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
